w25_flash_ctrl: RTL
===================

Name: w25_flash_ctrl

Overview:
Command sequencer for a W25-series SPI NOR flash.
- Sits between the UART command decoder and the byte-level SPI master, and owns chip-select.
- Turns one high-level request (read, page program, sector erase, JEDEC ID) into the full byte sequence: WREN, opcode, 24-bit address, data phase, CS deassert, and WIP status polling until the flash is ready.

Parameters:
- CS_GAP, 8: minimum clk cycles CS_N stays high between frames (range 1..255).
- POLL_MAX, 24'hFFFFFF: maximum status-poll reads before timeout (used only with W25_TIMEOUT_EN).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- cmd_valid  in  1  request strobe
- cmd_ready  out  1  high in IDLE only
- cmd_op  in  2  0=READ(0x03), 1=PAGE_PROG(0x02), 2=SECTOR_ERASE(0x20), 3=JEDEC_ID(0x9F)
- cmd_addr  in  24  flash byte address
- cmd_len  in  9  data byte count, 1..256 (READ/PROG); ignored otherwise
- wdata  in  8  program data byte
- wdata_valid  in  1  wdata present
- wdata_ready  out  1  pulses 1 cycle when wdata is consumed
- rdata  out  8  read byte (READ, JEDEC)
- rdata_valid  out  1  1-cycle pulse per rdata
- done  out  1  1-cycle pulse at end of request
- err  out  1  set with done on poll timeout; cleared at next accept
- spi_cs_n  out  1  flash chip select
- spi_wr  out  1  byte start to SPI master
- spi_din  out  8  byte to transmit
- spi_busy  in  1  SPI master busy
- spi_dout  in  8  byte received

Behaviour:
Reset values:
- Outputs: spi_cs_n=1, spi_wr=0, spi_din=0, cmd_ready=0 until IDLE, all pulses 0, err=0.
- FSM goes to IDLE on the first clk after reset release.

Byte handshake:
- Controller raises spi_wr for exactly one cycle, with spi_din stable, only when spi_busy=0.
- Next state waits for spi_busy=0. spi_dout is then valid and is sampled that cycle.
- spi_busy is combinationally high during the spi_wr cycle; the wait state must not sample it in that cycle.
- spi_din is held until busy falls.

Request acceptance:
- Accepted on cmd_valid & cmd_ready. op/addr/len are latched.
- cmd_len=0 is treated as 256. cmd_len>256 is clamped to 256.

FSM states: IDLE, WREN (CS low, send 0x06, CS high, gap), CMD, ADDR2, ADDR1, ADDR0, DATA, CS_OFF, GAP, POLL_CMD (0x05), POLL_RD, FIN.

Sequences:
- READ: CMD -> ADDR2..ADDR0 (MSB first) -> DATA, sending 0x00 len times. Each received byte gives rdata_valid -> CS_OFF -> GAP -> FIN.
- PAGE_PROG: WREN -> CMD -> ADDR -> DATA.
  - For each byte, wait for wdata_valid (CS stays low, no timeout), pulse wdata_ready, send wdata.
  - Then CS_OFF -> GAP -> POLL.
- SECTOR_ERASE: WREN -> CMD -> ADDR -> CS_OFF -> GAP -> POLL.
- JEDEC_ID: CMD -> 3 dummy-send DATA bytes, each giving rdata_valid -> CS_OFF -> GAP -> FIN.

POLL:
- CS low, send 0x05, then repeatedly send 0x00 and read status with CS held low.
- Exit when status bit0 (WIP)=0: CS_OFF -> GAP -> FIN.

Chip select and gaps:
- CS_N falls one cycle before the first spi_wr of a frame.
- CS_N rises only after the last byte's busy falls.
- GAP counts CS_GAP cycles with CS_N high.

FIN:
- Pulses done for 1 cycle, then returns to IDLE. cmd_ready=1 the following cycle.

Address handling: no address wrap handling. Page-boundary wrap is the flash's behaviour; the controller does not split requests.

Reset mid-operation: CS_N goes high immediately (async), the in-flight flash operation is abandoned, and no done is pulsed.

Simultaneous events: cmd_valid during a request is ignored (cmd_ready=0).

Optional Feature:
W25_TIMEOUT_EN:
- Defined: a 24-bit poll counter increments per status byte. Reaching POLL_MAX -> CS_OFF -> GAP -> FIN with err=1 and done=1.
- Undefined: no counter, polling is unbounded, err is tied 0.

Decomposition:
- Package w25_pkg: opcode localparams OP_WREN=8'h06, OP_READ=8'h03, OP_PP=8'h02, OP_SE=8'h20, OP_RDSR=8'h05, OP_JEDEC=8'h9F; cmd_op encodings; FSM state encoding.
- One sub-module, w25_byte_handshake: issues the one-cycle spi_wr, waits for busy to fall, presents rx byte with a done pulse. The main FSM uses it for every byte.

Test Plan:
- JEDEC_ID with flash model returning EF 40 18:
  - Required: rdata_valid x3 = 0xEF, 0x40, 0x18, then done.
  - Required: MOSI stream 9F 00 00 00 within a single CS low.
- READ addr=0x012345, len=4:
  - Required: MOSI stream 03 01 23 45 00 00 00 00.
  - Required: 4 rdata pulses match model memory, CS high >= CS_GAP before done.
- PAGE_PROG addr=0x000100, len=2, data A5 5A, status WIP=1 twice then 0:
  - Required frames: [06], [02 00 01 00 A5 5A], [05 xx xx xx].
  - Required: done=1, err=0.
- SECTOR_ERASE addr=0x003000, wdata_valid held low:
  - Required frames: [06], [20 00 30 00], poll.
  - Required: wdata_ready never pulses.
- Reset asserted mid-DATA of READ len=256:
  - Required: spi_cs_n=1 in the same cycle (async), no done, cmd_ready=1 after release.
- With W25_TIMEOUT_EN, POLL_MAX=16, WIP stuck 1:
  - Required: exactly 16 status reads, then done=1, err=1.

Source files
------------

// File: rtl/w25_pkg.sv
// Shared definitions for the W25 SPI NOR flash command sequencer:
// flash opcodes, request encodings and FSM state types.
package w25_pkg;

    localparam logic [7:0] OP_WREN  = 8'h06;
    localparam logic [7:0] OP_READ  = 8'h03;
    localparam logic [7:0] OP_PP    = 8'h02;
    localparam logic [7:0] OP_SE    = 8'h20;
    localparam logic [7:0] OP_RDSR  = 8'h05;
    localparam logic [7:0] OP_JEDEC = 8'h9F;

    localparam logic [8:0] MAX_LEN   = 9'd256;
    localparam logic [8:0] JEDEC_LEN = 9'd3;

    typedef enum logic [1:0] {
        CMD_READ  = 2'd0,
        CMD_PP    = 2'd1,
        CMD_SE    = 2'd2,
        CMD_JEDEC = 2'd3
    } cmd_op_e;

    typedef enum logic [3:0] {
        ST_RST,
        ST_IDLE,
        ST_WREN,
        ST_CMD,
        ST_ADDR2,
        ST_ADDR1,
        ST_ADDR0,
        ST_DATA,
        ST_CS_OFF,
        ST_GAP,
        ST_POLL_CMD,
        ST_POLL_RD,
        ST_FIN
    } state_e;

    typedef enum logic [1:0] {
        HS_IDLE,
        HS_WR,
        HS_WAIT
    } hs_state_e;

    function automatic logic [7:0] op_opcode(input cmd_op_e op);
        logic [7:0] code;
        case (op)
            CMD_READ:  code = OP_READ;
            CMD_PP:    code = OP_PP;
            CMD_SE:    code = OP_SE;
            CMD_JEDEC: code = OP_JEDEC;
            default:   code = OP_READ;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/w25_byte_handshake.sv
// One-byte exchange with the SPI master: one-cycle spi_wr, wait for busy to
// fall, capture the received byte and pulse done.
module w25_byte_handshake
    import w25_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] tx_byte,
    output logic       ready,
    output logic       done,
    output logic [7:0] rx_byte,
    output logic       spi_wr,
    output logic [7:0] spi_din,
    input  logic       spi_busy,
    input  logic [7:0] spi_dout
);

    hs_state_e  state_q, state_d;
    logic [7:0] din_q, din_d;
    logic [7:0] rx_q, rx_d;
    logic       done_q, done_d;

    // The done cycle is excluded so the caller can act on the result before
    // launching the next byte.
    assign ready   = (state_q == HS_IDLE) && !done_q && !spi_busy;
    assign done    = done_q;
    assign rx_byte = rx_q;
    assign spi_wr  = (state_q == HS_WR);
    assign spi_din = din_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= HS_IDLE;
            din_q   <= '0;
            rx_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            din_q   <= din_d;
            rx_q    <= rx_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        din_d   = din_q;
        rx_d    = rx_q;
        done_d  = 1'b0;
        case (state_q)
            HS_IDLE: begin
                if (start && ready) begin
                    din_d   = tx_byte;
                    state_d = HS_WR;
                end
            end
            // busy is forced high by the master during the spi_wr cycle itself
            HS_WR: state_d = HS_WAIT;
            HS_WAIT: begin
                if (!spi_busy) begin
                    rx_d    = spi_dout;
                    done_d  = 1'b1;
                    state_d = HS_IDLE;
                end
            end
            default: state_d = HS_IDLE;
        endcase
    end

endmodule

// File: rtl/w25_flash_ctrl.sv
// W25 SPI NOR flash command sequencer (READ, PAGE_PROG, SECTOR_ERASE, JEDEC_ID).
// Define W25_TIMEOUT_EN to bound WIP polling at POLL_MAX status reads (err on expiry).
module w25_flash_ctrl
    import w25_pkg::*;
#(
    parameter int unsigned CS_GAP   = 8,
    parameter logic [23:0] POLL_MAX = 24'hFFFFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [23:0] cmd_addr,
    input  logic [8:0]  cmd_len,
    input  logic [7:0]  wdata,
    input  logic        wdata_valid,
    output logic        wdata_ready,
    output logic [7:0]  rdata,
    output logic        rdata_valid,
    output logic        done,
    output logic        err,
    output logic        spi_cs_n,
    output logic        spi_wr,
    output logic [7:0]  spi_din,
    input  logic        spi_busy,
    input  logic [7:0]  spi_dout
);

    state_e      state_q, state_d;
    state_e      ret_q, ret_d;
    cmd_op_e     op_q, op_d;
    logic [23:0] addr_q, addr_d;
    logic [8:0]  cnt_q, cnt_d;
    logic [7:0]  gap_q, gap_d;
    logic        cs_n_q, cs_n_d;

    logic        hs_start;
    logic [7:0]  hs_tx;
    logic        hs_ready;
    logic        hs_done;
    logic [7:0]  hs_rx;
    logic        byte_state;
    logic        tx_hold;
    logic        accept;
    logic        poll_hit;
    cmd_op_e     req_op;

    w25_byte_handshake u_hs (
        .clk      (clk),
        .rst      (rst),
        .start    (hs_start),
        .tx_byte  (hs_tx),
        .ready    (hs_ready),
        .done     (hs_done),
        .rx_byte  (hs_rx),
        .spi_wr   (spi_wr),
        .spi_din  (spi_din),
        .spi_busy (spi_busy),
        .spi_dout (spi_dout)
    );

    assign req_op      = cmd_op_e'(cmd_op);
    assign accept      = (state_q == ST_IDLE) && cmd_valid;
    assign cmd_ready   = (state_q == ST_IDLE);
    assign done        = (state_q == ST_FIN);
    assign spi_cs_n    = cs_n_q;
    assign rdata       = hs_rx;
    assign rdata_valid = hs_done && (state_q == ST_DATA) && (op_q != CMD_PP);
    assign hs_start    = byte_state && hs_ready && !tx_hold;
    assign wdata_ready = hs_start && (state_q == ST_DATA) && (op_q == CMD_PP);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RST;
            ret_q   <= ST_FIN;
            op_q    <= CMD_READ;
            addr_q  <= '0;
            cnt_q   <= '0;
            gap_q   <= '0;
            cs_n_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            ret_q   <= ret_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
            cs_n_q  <= cs_n_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        ret_d      = ret_q;
        op_d       = op_q;
        addr_d     = addr_q;
        cnt_d      = cnt_q;
        gap_d      = gap_q;
        cs_n_d     = cs_n_q;
        hs_tx      = '0;
        byte_state = 1'b0;
        tx_hold    = 1'b0;
        case (state_q)
            ST_RST: state_d = ST_IDLE;
            // CS drops on entry to every frame's first byte state, so it
            // leads the first spi_wr by exactly one cycle.
            ST_IDLE: begin
                if (accept) begin
                    op_d   = req_op;
                    addr_d = cmd_addr;
                    if (req_op == CMD_JEDEC) begin
                        cnt_d = JEDEC_LEN;
                    end else if (cmd_len == 9'd0 || cmd_len > MAX_LEN) begin
                        cnt_d = MAX_LEN;
                    end else begin
                        cnt_d = cmd_len;
                    end
                    cs_n_d  = 1'b0;
                    state_d = (req_op == CMD_PP || req_op == CMD_SE) ? ST_WREN : ST_CMD;
                end
            end
            ST_WREN: begin
                byte_state = 1'b1;
                hs_tx      = OP_WREN;
                if (hs_done) begin
                    ret_d   = ST_CMD;
                    state_d = ST_CS_OFF;
                end
            end
            ST_CMD: begin
                byte_state = 1'b1;
                hs_tx      = op_opcode(op_q);
                if (hs_done) begin
                    state_d = (op_q == CMD_JEDEC) ? ST_DATA : ST_ADDR2;
                end
            end
            ST_ADDR2: begin
                byte_state = 1'b1;
                hs_tx      = addr_q[23:16];
                if (hs_done) state_d = ST_ADDR1;
            end
            ST_ADDR1: begin
                byte_state = 1'b1;
                hs_tx      = addr_q[15:8];
                if (hs_done) state_d = ST_ADDR0;
            end
            ST_ADDR0: begin
                byte_state = 1'b1;
                hs_tx      = addr_q[7:0];
                if (hs_done) begin
                    if (op_q == CMD_SE) begin
                        ret_d   = ST_POLL_CMD;
                        state_d = ST_CS_OFF;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                byte_state = 1'b1;
                if (op_q == CMD_PP) begin
                    hs_tx   = wdata;
                    tx_hold = !wdata_valid;
                end
                if (hs_done) begin
                    if (cnt_q == 9'd1) begin
                        ret_d   = (op_q == CMD_PP) ? ST_POLL_CMD : ST_FIN;
                        state_d = ST_CS_OFF;
                    end else begin
                        cnt_d = cnt_q - 9'd1;
                    end
                end
            end
            ST_CS_OFF: begin
                cs_n_d  = 1'b1;
                gap_d   = 8'(CS_GAP - 1);
                state_d = ST_GAP;
            end
            ST_GAP: begin
                if (gap_q == 8'd0) begin
                    state_d = ret_q;
                    cs_n_d  = (ret_q == ST_FIN);
                end else begin
                    gap_d = gap_q - 8'd1;
                end
            end
            ST_POLL_CMD: begin
                byte_state = 1'b1;
                hs_tx      = OP_RDSR;
                if (hs_done) state_d = ST_POLL_RD;
            end
            ST_POLL_RD: begin
                byte_state = 1'b1;
                if (hs_done && (!hs_rx[0] || poll_hit)) begin
                    ret_d   = ST_FIN;
                    state_d = ST_CS_OFF;
                end
            end
            ST_FIN: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

`ifdef W25_TIMEOUT_EN
    logic [23:0] poll_cnt_q, poll_cnt_d;
    logic        tmo_q, tmo_d;
    logic        err_q, err_d;

    // poll_cnt counts WIP=1 reads already seen; the read that lands on
    // POLL_MAX-1 is the POLL_MAX-th and ends the poll.
    assign poll_hit = (poll_cnt_q == POLL_MAX - 24'd1);
    assign err      = err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            poll_cnt_q <= '0;
            tmo_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            poll_cnt_q <= poll_cnt_d;
            tmo_q      <= tmo_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        poll_cnt_d = poll_cnt_q;
        tmo_d      = tmo_q;
        err_d      = err_q;
        if (accept) begin
            tmo_d = 1'b0;
            err_d = 1'b0;
        end
        if (state_q == ST_POLL_CMD) poll_cnt_d = '0;
        if (state_q == ST_POLL_RD && hs_done && hs_rx[0]) begin
            if (poll_hit) tmo_d = 1'b1;
            else          poll_cnt_d = poll_cnt_q + 24'd1;
        end
        if (state_q == ST_GAP && gap_q == 8'd0 && ret_q == ST_FIN) err_d = tmo_q;
    end
`else
    logic unused_poll_max;

    assign unused_poll_max = ^POLL_MAX;
    assign poll_hit        = 1'b0;
    assign err             = 1'b0;
`endif

endmodule
